instr_loader: RTL and testbench

Program loader that fills the 32-word instruction memory before the single-cycle processor runs. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and issues one write per word to the instruction RAM write port at incrementing word addresses from 0. While loading, it asserts a hold to the processor so the PC and register file stay frozen. It signals completion when the requested word count has been written.

---
 rtl/instr_loader.sv | 124 ++++++++++++
 tb/tb_instr_loader.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Program loader: assembles big-endian bytes into 32-bit words and writes them
// to instruction RAM at addresses 0.., holding the processor until the load ends.
module instr_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [5:0]        word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [5:0]        count_q, count_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       asm_q, asm_d;

    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept;
    logic              last_word;

    assign accept    = in_valid && in_ready_q;
    assign last_word = (32'(word_idx_q) + 32'd1) == 32'(count_q);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Saturating the count keeps every address below DEPTH.
                    count_d    = (32'(word_count) > DEPTH) ? 6'(DEPTH) : word_count;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    state_d    = (count_d == 6'd0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    asm_d      = {asm_q[23:0], in_byte};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d   = WRITE;
                        wr_addr_d = word_idx_q;
                        wr_data_d = {asm_q[23:0], in_byte};
                    end
                end
            end
            WRITE: begin
                word_idx_d = word_idx_q + 1'b1;
                state_d    = last_word ? DONE : LOAD;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered
        // and line up with the state they describe.
        in_ready_d = (state_d == LOAD);
        wr_en_d    = (state_d == WRITE);
        busy_d     = (state_d == LOAD) || (state_d == WRITE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign cpu_hold = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_instr_loader.sv
// Randomized self-checking bench for instr_loader against a byte-stream word model.
module tb_instr_loader;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [5:0]        word_count;
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              busy;
    logic              done;

    instr_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]        stim_bytes[$];
    logic [ADDR_W-1:0] log_addr[$];
    logic [31:0]       log_data[$];
    int                rdy_viol = 0;

    // Write monitor: records every RAM write seen on the port.
    always @(negedge clk) begin
        if (wr_en) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
            if (in_ready) rdy_viol++;
        end
    end

    // Reference: word i is bytes 4i..4i+3, most significant first.
    function automatic logic [31:0] model_word(int i);
        return (32'(stim_bytes[4*i]) << 24) | (32'(stim_bytes[4*i+1]) << 16) |
               (32'(stim_bytes[4*i+2]) << 8) | 32'(stim_bytes[4*i+3]);
    endfunction

    function automatic int model_count(int cnt);
        return (cnt > DEPTH) ? DEPTH : cnt;
    endfunction

    task automatic clear_logs();
        log_addr.delete();
        log_data.delete();
        rdy_viol = 0;
    endtask

    task automatic set_random_bytes(int n);
        stim_bytes.delete();
        for (int i = 0; i < n; i++) stim_bytes.push_back(8'($urandom));
    endtask

    // Stimulus driver: start a load and stream stim_bytes; reports cycles from
    // LOAD entry until done (-1 on timeout), bytes accepted and hold drops.
    task automatic drive_load(input int cnt, input int gap_pct, input int restart_at,
                              input int stop_after, input int max_cyc,
                              output int acc, output int cyc, output int hold_bad);
        int c;
        bit will;
        acc = 0;
        cyc = -1;
        hold_bad = 0;
        @(negedge clk);
        start = 1'b1;
        word_count = 6'(cnt);
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (c = 0; c < max_cyc; c++) begin
            if (done) begin
                cyc = c;
                break;
            end
            if (stop_after >= 0 && acc >= stop_after) break;
            if (!busy || !cpu_hold) hold_bad++;
            start = (c == restart_at);
            if (start) word_count = 6'd1;
            if (acc < stim_bytes.size() && $urandom_range(99) >= gap_pct) begin
                in_valid = 1'b1;
                in_byte = stim_bytes[acc];
            end else begin
                in_valid = 1'b0;
                in_byte = 8'($urandom);
            end
            will = in_valid && in_ready;
            @(posedge clk);
            if (will) acc++;
            @(negedge clk);
        end
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        word_count = '0;
        in_valid = 1'b0;
        in_byte = '0;
        #12;
        n_vec++;
        if ({in_ready, wr_en, busy, cpu_hold, done, wr_addr, wr_data} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b wen=%b busy=%b hold=%b done=%b addr=%0d data=%h, want all 0",
                     in_ready, wr_en, busy, cpu_hold, done, wr_addr, wr_data);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int acc, cyc, hb;
        logic [31:0] exp_w [2];
        exp_w[0] = 32'h20020005;
        exp_w[1] = 32'h2003000c;
        stim_bytes = '{8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h0c};
        clear_logs();
        drive_load(2, 0, -1, -1, 100, acc, cyc, hb);
        n_vec++;
        if (cyc !== 10) begin
            n_err++;
            $display("FAIL basic_done_latency: got %0d cycles, want 10", cyc);
        end
        n_vec++;
        if (hb !== 0 || busy !== 1'b0 || cpu_hold !== 1'b0) begin
            n_err++;
            $display("FAIL basic_hold: %0d hold drops, busy=%b hold=%b at done, want 0/0/0", hb, busy, cpu_hold);
        end
        n_vec++;
        if (log_addr.size() !== 2) begin
            n_err++;
            $display("FAIL basic_write_count: got %0d, want 2", log_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (log_addr[i] !== ADDR_W'(i) || log_data[i] !== exp_w[i]) begin
                    n_err++;
                    $display("FAIL basic_write%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                             i, log_addr[i], log_data[i], i, exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int acc, cyc, hb, cnt;
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin
                cnt = 2;
                stim_bytes = '{8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h0c};
            end else begin
                cnt = 1 + int'($urandom_range(6));
                set_random_bytes(4 * cnt);
            end
            clear_logs();
            drive_load(cnt, 50, -1, -1, 2000, acc, cyc, hb);
            n_vec++;
            if (cyc < 5 * cnt || acc !== 4 * cnt || hb !== 0 || rdy_viol !== 0) begin
                n_err++;
                $display("FAIL gaps%0d_flow: cyc=%0d acc=%0d holddrops=%0d rdy_on_write=%0d, want cyc>=%0d acc=%0d 0 0",
                         k, cyc, acc, hb, rdy_viol, 5 * cnt, 4 * cnt);
            end
            n_vec++;
            if (log_addr.size() !== cnt) begin
                n_err++;
                $display("FAIL gaps%0d_write_count: got %0d, want %0d", k, log_addr.size(), cnt);
            end else begin
                for (int i = 0; i < cnt; i++) begin
                    n_vec++;
                    if (log_addr[i] !== ADDR_W'(i) || log_data[i] !== model_word(i)) begin
                        n_err++;
                        $display("FAIL gaps%0d_write%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                                 k, i, log_addr[i], log_data[i], i, model_word(i));
                    end
                end
            end
        end
    endtask

    task automatic test_zero_sat();
        int acc, cyc, hb, late_acc, n;
        stim_bytes.delete();
        clear_logs();
        drive_load(0, 0, -1, -1, 20, acc, cyc, hb);
        repeat (2) @(negedge clk);
        n_vec++;
        if (cyc !== 0 || log_addr.size() !== 0 || done !== 1'b1) begin
            n_err++;
            $display("FAIL zero_count: cyc=%0d writes=%0d done=%b, want 0 0 1", cyc, log_addr.size(), done);
        end

        set_random_bytes(160);
        clear_logs();
        n = model_count(40);
        drive_load(40, 0, -1, -1, 400, acc, cyc, hb);
        n_vec++;
        if (cyc !== 5 * n || acc !== 4 * n) begin
            n_err++;
            $display("FAIL sat_flow: cyc=%0d acc=%0d, want %0d %0d", cyc, acc, 5 * n, 4 * n);
        end
        // Offer leftover bytes while DONE: none may be taken.
        late_acc = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_byte = stim_bytes[128 + i];
            if (in_ready) late_acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_vec++;
        if (late_acc !== 0 || log_addr.size() !== n) begin
            n_err++;
            $display("FAIL sat_after_done: accepted=%0d writes=%0d, want 0 %0d", late_acc, log_addr.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                n_vec++;
                if (log_addr[i] !== ADDR_W'(i) || log_data[i] !== model_word(i)) begin
                    n_err++;
                    $display("FAIL sat_write%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                             i, log_addr[i], log_data[i], i, model_word(i));
                end
            end
        end
    endtask

    task automatic test_start_busy();
        int acc, cyc, hb;
        set_random_bytes(20);
        clear_logs();
        drive_load(5, 0, 6, -1, 200, acc, cyc, hb);
        n_vec++;
        if (cyc !== 25 || acc !== 20 || log_addr.size() !== 5) begin
            n_err++;
            $display("FAIL busy_start_flow: cyc=%0d acc=%0d writes=%0d, want 25 20 5", cyc, acc, log_addr.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_vec++;
                if (log_addr[i] !== ADDR_W'(i) || log_data[i] !== model_word(i)) begin
                    n_err++;
                    $display("FAIL busy_start_write%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                             i, log_addr[i], log_data[i], i, model_word(i));
                end
            end
        end
    endtask

    task automatic test_reset_midload();
        int acc, cyc, hb;
        logic [31:0] w0;
        set_random_bytes(12);
        w0 = model_word(0);
        clear_logs();
        drive_load(3, 0, -1, 6, 100, acc, cyc, hb);
        #3;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({in_ready, wr_en, busy, cpu_hold, done, wr_addr, wr_data} !== '0) begin
            n_err++;
            $display("FAIL midload_reset_outputs: got rdy=%b wen=%b busy=%b hold=%b done=%b addr=%0d data=%h, want all 0",
                     in_ready, wr_en, busy, cpu_hold, done, wr_addr, wr_data);
        end
        n_vec++;
        if (acc !== 6 || log_addr.size() !== 1 || log_addr[0] !== '0 || log_data[0] !== w0) begin
            n_err++;
            $display("FAIL midload_writes: acc=%0d writes=%0d first=%h, want 6 1 %h",
                     acc, log_addr.size(), (log_data.size() > 0) ? log_data[0] : 32'hx, w0);
        end
        @(negedge clk);
        rst = 1'b0;
        set_random_bytes(4);
        clear_logs();
        drive_load(1, 0, -1, -1, 50, acc, cyc, hb);
        n_vec++;
        if (cyc !== 5 || log_addr.size() !== 1 || log_addr[0] !== '0 || log_data[0] !== model_word(0)) begin
            n_err++;
            $display("FAIL midload_fresh_load: cyc=%0d writes=%0d data=%h, want 5 1 %h",
                     cyc, log_addr.size(), (log_data.size() > 0) ? log_data[0] : 32'hx, model_word(0));
        end
    endtask

    task automatic test_reload();
        int acc, cyc, hb;
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL reload_precondition: done=%b, want 1", done);
        end
        stim_bytes = '{8'h8c, 8'h02, 8'h00, 8'h50};
        clear_logs();
        drive_load(1, 0, -1, -1, 50, acc, cyc, hb);
        n_vec++;
        if (cyc !== 5 || hb !== 0 || log_addr.size() !== 1 || log_addr[0] !== '0 ||
            log_data[0] !== 32'h8c020050) begin
            n_err++;
            $display("FAIL reload: cyc=%0d holddrops=%0d writes=%0d data=%h, want 5 0 1 8c020050",
                     cyc, hb, log_addr.size(), (log_data.size() > 0) ? log_data[0] : 32'hx);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_sat();
        test_start_busy();
        test_reset_midload();
        test_reload();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
